decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/decode_regfile.sv | 39 +++
 rtl/decode_issue.sv | 201 ++++++++++++++++++++
 tb/tb_decode_issue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants: RV opcodes, ex_flags bit positions, canonical NOP
// and sign-extending immediate extractors.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam int FLG_WB   = 0;
  localparam int FLG_IMM  = 1;
  localparam int FLG_MEM  = 2;
  localparam int FLG_LOAD = 3;
  localparam int FLG_BR   = 4;
  localparam int FLG_WORD = 5;
  localparam int FLG_ILL  = 6;
  localparam int FLG_W    = 7;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
    return 32'(signed'(inst[31:20]));
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] inst);
    return 32'(signed'({inst[31:25], inst[11:7]}));
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return 32'(signed'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] inst);
    return signed'({inst[31:12], 12'h000});
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return 32'(signed'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Integer register file: two combinational read ports, one write port with
// same-cycle write-through, x0 hardwired to zero, x3 resets to GP_RESET.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] GP_RESET = 'h20200
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  output logic [XLEN-1:0] o_rdata1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [0:31];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= (i == 3) ? GP_RESET : '0;
    end else if (i_we && i_waddr != 5'd0) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] ra);
    if (ra == 5'd0) return '0;
    if (i_we && i_waddr == ra) return i_wdata;
    return r_regs[ra];
  endfunction

  assign o_rdata1 = rd_port(i_raddr1);
  assign o_rdata2 = rd_port(i_raddr2);

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes the fetch word, resolves operands through the
// forwarding network, stalls on pending loads and registers one issue slot.
module decode_issue
  import decode_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              NUM_FWD  = 2,
  parameter logic [XLEN-1:0] GP_RESET = 'h20200
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    if_valid,
  output logic                    if_ready,
  input  logic [31:0]             if_inst,
  input  logic [XLEN-1:0]         if_pc,
  input  logic                    flush,
  input  logic                    wb_en,
  input  logic [4:0]              wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [4:0]              ex_rd,
  output logic [4:0]              ex_rs1,
  output logic [4:0]              ex_rs2,
  output logic [2:0]              ex_funct3,
  output logic [6:0]              ex_funct7,
  output logic [2:0]              ex_mem_para,
  output logic [XLEN-1:0]         ex_op1,
  output logic [XLEN-1:0]         ex_op2,
  output logic [XLEN-1:0]         ex_store_data,
  output logic [XLEN-1:0]         ex_branch_off,
  output logic [XLEN-1:0]         ex_pc,
  output logic [FLG_W-1:0]        ex_flags,
  output logic                    jalr_valid,
  output logic [XLEN-1:0]         jalr_target
);

  logic [31:0]      w_inst;
  logic [XLEN-1:0]  w_rf1, w_rf2, w_src1, w_src2, w_jsum;
  logic             w_pend1, w_pend2, w_use1, w_use2, w_jalr, w_ill;
  logic             w_hazard, w_accept;
  logic [4:0]       w_rd, w_rs1, w_rs2;
  logic [2:0]       w_f3, w_mp;
  logic [6:0]       w_f7;
  logic [XLEN-1:0]  w_op1, w_op2, w_sd, w_bo;
  logic [FLG_W-1:0] w_flags;

  // An empty fetch slot decodes as a NOP so it never raises a hazard.
  assign w_inst = if_valid ? if_inst : NOP_INST;

  decode_regfile #(.XLEN(XLEN), .GP_RESET(GP_RESET)) u_regfile (
    .CLK(CLK), .reset(reset),
    .i_we(wb_en), .i_waddr(wb_rd), .i_wdata(wb_data),
    .i_raddr1(w_inst[19:15]), .o_rdata1(w_rf1),
    .i_raddr2(w_inst[24:20]), .o_rdata2(w_rf2)
  );

  // Returns {pending, value}; scanning downward lets the youngest port win.
  function automatic logic [XLEN:0] resolve(input logic [4:0] ra,
                                            input logic [XLEN-1:0] rf_val);
    logic [XLEN:0] res;
    res = {1'b0, rf_val};
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == ra)
        res = {fwd_pending[i], fwd_data[XLEN*i +: XLEN]};
    end
    if (ra == 5'd0) res = '0;
    return res;
  endfunction

  assign {w_pend1, w_src1} = resolve(w_inst[19:15], w_rf1);
  assign {w_pend2, w_src2} = resolve(w_inst[24:20], w_rf2);

  assign w_hazard = (w_use1 && w_pend1) || (w_use2 && w_pend2);
  assign if_ready = reset && !w_hazard && (!ex_valid || ex_ready) && !flush;
  assign w_accept = if_valid && if_ready;
  assign w_jsum   = w_src1 + XLEN'(imm_i(w_inst));

  always_comb begin
    w_rd    = w_inst[11:7];
    w_rs1   = w_inst[19:15];
    w_rs2   = w_inst[24:20];
    w_f3    = w_inst[14:12];
    w_f7    = w_inst[31:25];
    w_mp    = 3'd0;
    w_op1   = w_src1;
    w_op2   = w_src2;
    w_sd    = '0;
    w_bo    = '0;
    w_flags = '0;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_jalr  = 1'b0;
    w_ill   = 1'b0;
    case (w_inst[6:0])
      OPC_OP: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_flags[FLG_WB] = 1'b1;
      end
      OPC_OP_IMM: begin
        w_use1 = 1'b1; w_rs2 = 5'd0; w_op2 = XLEN'(imm_i(w_inst));
        w_flags[FLG_WB] = 1'b1; w_flags[FLG_IMM] = 1'b1;
      end
      OPC_LOAD: begin
        w_use1 = 1'b1; w_rs2 = 5'd0; w_f3 = 3'd0; w_f7 = 7'd0; w_mp = w_inst[14:12];
        w_op2 = XLEN'(imm_i(w_inst));
        w_flags[FLG_WB] = 1'b1; w_flags[FLG_IMM] = 1'b1;
        w_flags[FLG_MEM] = 1'b1; w_flags[FLG_LOAD] = 1'b1;
      end
      OPC_STORE: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_rd = 5'd0; w_f3 = 3'd0; w_f7 = 7'd0;
        w_mp = w_inst[14:12]; w_op2 = XLEN'(imm_s(w_inst)); w_sd = w_src2;
        w_flags[FLG_IMM] = 1'b1; w_flags[FLG_MEM] = 1'b1;
      end
      OPC_BRANCH: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_rd = 5'd0; w_f7 = 7'd0;
        w_bo = XLEN'(imm_b(w_inst)); w_flags[FLG_BR] = 1'b1;
      end
      OPC_JAL: begin
        w_rs1 = 5'd0; w_rs2 = 5'd0; w_f3 = 3'd0; w_f7 = 7'd0;
        w_op1 = if_pc; w_op2 = XLEN'(4); w_bo = XLEN'(imm_j(w_inst));
        w_flags[FLG_WB] = 1'b1;
      end
      OPC_JALR: begin
        w_use1 = 1'b1; w_jalr = 1'b1;
        w_rs1 = 5'd0; w_rs2 = 5'd0; w_f3 = 3'd0; w_f7 = 7'd0;
        w_op1 = if_pc; w_op2 = XLEN'(4);
        w_flags[FLG_WB] = 1'b1; w_flags[FLG_IMM] = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_rs1 = 5'd0; w_rs2 = 5'd0; w_f3 = 3'd0; w_f7 = 7'd0;
        w_op1 = XLEN'(imm_u(w_inst));
        w_op2 = (w_inst[6:0] == OPC_AUIPC) ? if_pc : '0;
        w_flags[FLG_WB] = 1'b1; w_flags[FLG_IMM] = 1'b1;
      end
      OPC_OP_32, OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          w_use1 = 1'b1; w_flags[FLG_WB] = 1'b1; w_flags[FLG_WORD] = 1'b1;
          if (w_inst[6:0] == OPC_OP_32) begin
            w_use2 = 1'b1;
          end else begin
            w_rs2 = 5'd0; w_op2 = XLEN'(imm_i(w_inst)); w_flags[FLG_IMM] = 1'b1;
          end
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_rd = 5'd0; w_rs1 = 5'd0; w_rs2 = 5'd0; w_f3 = 3'd0; w_f7 = 7'd0;
      w_op1 = '0; w_op2 = '0;
      w_flags = '0; w_flags[FLG_ILL] = 1'b1;
    end
  end

  // Issue register: payload only moves on accept, so it holds through stalls.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      jalr_valid    <= 1'b0;
      jalr_target   <= '0;
      ex_rd         <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_funct3     <= '0;
      ex_funct7     <= '0;
      ex_mem_para   <= '0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_store_data <= '0;
      ex_branch_off <= '0;
      ex_pc         <= '0;
      ex_flags      <= '0;
    end else begin
      jalr_valid <= w_accept && w_jalr;
      if (flush)         ex_valid <= 1'b0;
      else if (w_accept) ex_valid <= 1'b1;
      else if (ex_ready) ex_valid <= 1'b0;
      if (w_accept) begin
        ex_rd         <= w_rd;
        ex_rs1        <= w_rs1;
        ex_rs2        <= w_rs2;
        ex_funct3     <= w_f3;
        ex_funct7     <= w_f7;
        ex_mem_para   <= w_mp;
        ex_op1        <= w_op1;
        ex_op2        <= w_op2;
        ex_store_data <= w_sd;
        ex_branch_off <= w_bo;
        ex_pc         <= if_pc;
        ex_flags      <= w_flags;
        jalr_target   <= {w_jsum[XLEN-1:1], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: 64-bit instance plus a 32-bit instance on
// the same stimulus for the RV32 illegal-opcode case.
module tb_decode_issue;

  logic         CLK = 1'b0;
  logic         reset;
  logic         if_valid, if_ready, flush, wb_en, ex_ready, ex_valid, jalr_valid;
  logic [31:0]  if_inst;
  logic [63:0]  if_pc, wb_data, ex_op1, ex_op2, ex_store_data, ex_branch_off, ex_pc, jalr_target;
  logic [4:0]   wb_rd, ex_rd, ex_rs1, ex_rs2;
  logic [1:0]   fwd_valid, fwd_pending;
  logic [9:0]   fwd_rd;
  logic [127:0] fwd_data;
  logic [2:0]   ex_funct3, ex_mem_para;
  logic [6:0]   ex_funct7, ex_flags;

  logic         if_ready_32, ex_valid_32, jalr_valid_32;
  logic [4:0]   ex_rd_32, ex_rs1_32, ex_rs2_32;
  logic [2:0]   ex_funct3_32, ex_mem_para_32;
  logic [6:0]   ex_funct7_32, ex_flags_32;
  logic [31:0]  ex_op1_32, ex_op2_32, ex_sd_32, ex_bo_32, ex_pc_32, jalr_target_32;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  decode_issue u_dut (
    .CLK(CLK), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_mem_para(ex_mem_para),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data),
    .ex_branch_off(ex_branch_off), .ex_pc(ex_pc), .ex_flags(ex_flags),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target)
  );

  decode_issue #(.XLEN(32)) u_dut32 (
    .CLK(CLK), .reset(reset), .if_valid(if_valid), .if_ready(if_ready_32),
    .if_inst(if_inst), .if_pc(if_pc[31:0]), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data({fwd_data[95:64], fwd_data[31:0]}),
    .fwd_pending(fwd_pending),
    .ex_valid(ex_valid_32), .ex_ready(ex_ready), .ex_rd(ex_rd_32), .ex_rs1(ex_rs1_32),
    .ex_rs2(ex_rs2_32), .ex_funct3(ex_funct3_32), .ex_funct7(ex_funct7_32),
    .ex_mem_para(ex_mem_para_32), .ex_op1(ex_op1_32), .ex_op2(ex_op2_32),
    .ex_store_data(ex_sd_32), .ex_branch_off(ex_bo_32), .ex_pc(ex_pc_32),
    .ex_flags(ex_flags_32), .jalr_valid(jalr_valid_32), .jalr_target(jalr_target_32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] add_ins(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction

  task automatic wb_write(input logic [4:0] rd, input logic [63:0] val);
    wb_en = 1'b1; wb_rd = rd; wb_data = val;
    tick();
    wb_en = 1'b0;
  endtask

  // ex_flags bits, LSB first: write_back, imm, mem_acc, load, branch, word, illegal
  initial begin
    reset = 1'b0; if_valid = 1'b1; if_inst = add_ins(5'd1, 5'd1, 5'd1); if_pc = 64'h0;
    flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'h0; ex_ready = 1'b1;
    fwd_valid = 2'b00; fwd_rd = 10'd0; fwd_data = 128'h0; fwd_pending = 2'b00;

    tick(); tick();
    chk("rst_if_ready", 64'(if_ready), 64'h0);
    chk("rst_ex_valid", 64'(ex_valid), 64'h0);
    chk("rst_jalr_valid", 64'(jalr_valid), 64'h0);
    chk("rst_ex_op1", ex_op1, 64'h0);
    chk("rst_ex_flags", 64'(ex_flags), 64'h0);
    reset = 1'b1; if_valid = 1'b0;

    wb_write(5'd1, 64'd5);
    wb_write(5'd2, 64'd7);
    chk("idle_ex_valid", 64'(ex_valid), 64'h0);

    // x3 holds its reset value
    if_valid = 1'b1; if_inst = i_ins(12'd0, 5'd3, 5'd5, 7'b0010011); if_pc = 64'h0ffc;
    #1 chk("gp_if_ready", 64'(if_ready), 64'h1);
    tick();
    chk("gp_op1", ex_op1, 64'h20200);
    chk("gp_flags", 64'(ex_flags), 64'h03);

    if_inst = add_ins(5'd3, 5'd1, 5'd2); if_pc = 64'h1000;
    tick();
    chk("add_valid", 64'(ex_valid), 64'h1);
    chk("add_op1", ex_op1, 64'd5);
    chk("add_op2", ex_op2, 64'd7);
    chk("add_flags", 64'(ex_flags), 64'h01);
    chk("add_pc", ex_pc, 64'h1000);
    chk("add_rd", 64'(ex_rd), 64'd3);

    // pending load on port 0 targets x1
    fwd_valid = 2'b01; fwd_rd = 10'd1; fwd_pending = 2'b01; fwd_data = 128'h0;
    if_inst = add_ins(5'd4, 5'd1, 5'd0);
    #1 chk("haz_if_ready", 64'(if_ready), 64'h0);
    tick();
    chk("haz_bubble", 64'(ex_valid), 64'h0);
    fwd_pending = 2'b00; fwd_data = {64'h0, 64'd9};
    #1 chk("haz_clear_ready", 64'(if_ready), 64'h1);
    tick();
    chk("haz_valid", 64'(ex_valid), 64'h1);
    chk("haz_op1", ex_op1, 64'd9);
    chk("haz_op2", ex_op2, 64'd0);

    fwd_valid = 2'b11; fwd_rd = {5'd2, 5'd2}; fwd_data = {64'd8, 64'd3};
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 64'h55;
    if_inst = add_ins(5'd5, 5'd0, 5'd2);
    tick();
    chk("prio_op2", ex_op2, 64'd3);
    chk("prio_op1_x0", ex_op1, 64'd0);
    wb_en = 1'b0; fwd_valid = 2'b00;
    if_inst = add_ins(5'd6, 5'd2, 5'd0);
    tick();
    chk("rf_op1", ex_op1, 64'h55);

    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
    if_inst = add_ins(5'd8, 5'd7, 5'd0);
    tick();
    wb_en = 1'b0;
    chk("wthru_op1", ex_op1, 64'h77);

    fwd_valid = 2'b01; fwd_rd = 10'd0; fwd_data = {64'h0, 64'h99};
    if_inst = add_ins(5'd9, 5'd0, 5'd1);
    tick();
    fwd_valid = 2'b00;
    chk("x0_op1", ex_op1, 64'd0);
    chk("x0_op2", ex_op2, 64'd5);

    if_valid = 1'b0;
    wb_write(5'd6, 64'h100);
    if_valid = 1'b1; if_inst = i_ins(12'd5, 5'd6, 5'd1, 7'b1100111); if_pc = 64'h2000;
    tick();
    chk("jalr_valid", 64'(jalr_valid), 64'h1);
    chk("jalr_target", jalr_target, 64'h104);
    chk("jalr_op1", ex_op1, 64'h2000);
    chk("jalr_op2", ex_op2, 64'd4);
    chk("jalr_rs1", 64'(ex_rs1), 64'd0);
    if_valid = 1'b0;
    tick();
    chk("jalr_pulse", 64'(jalr_valid), 64'h0);

    if_valid = 1'b1; if_inst = i_ins(12'hfff, 5'd1, 5'd10, 7'b0010011);
    tick();
    chk("neg_imm_op2", ex_op2, 64'hffff_ffff_ffff_ffff);
    ex_ready = 1'b0; if_inst = add_ins(5'd11, 5'd1, 5'd1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_if_ready", 64'(if_ready), 64'h0);
      tick();
      chk("stall_valid", 64'(ex_valid), 64'h1);
      chk("stall_op2", ex_op2, 64'hffff_ffff_ffff_ffff);
      chk("stall_rd", 64'(ex_rd), 64'd10);
    end
    flush = 1'b1;
    #1 chk("flush_if_ready", 64'(if_ready), 64'h0);
    tick();
    chk("flush_valid", 64'(ex_valid), 64'h0);
    flush = 1'b0; ex_ready = 1'b1;

    if_inst = 32'h0000_007f;
    tick();
    chk("ill_valid", 64'(ex_valid), 64'h1);
    chk("ill_flags", 64'(ex_flags), 64'h40);

    // sd x2,8(x1)
    if_inst = {7'd0, 5'd2, 5'd1, 3'b011, 5'd8, 7'b0100011};
    tick();
    chk("st_rd", 64'(ex_rd), 64'd0);
    chk("st_funct3", 64'(ex_funct3), 64'd0);
    chk("st_mem_para", 64'(ex_mem_para), 64'd3);
    chk("st_op2", ex_op2, 64'd8);
    chk("st_data", ex_store_data, 64'h55);
    chk("st_flags", 64'(ex_flags), 64'h06);

    // addiw x1,x1,1
    if_inst = i_ins(12'd1, 5'd1, 5'd1, 7'b0011011);
    tick();
    chk("addiw64_flags", 64'(ex_flags), 64'h23);
    chk("addiw64_op1", ex_op1, 64'd5);
    chk("addiw32_valid", 64'(ex_valid_32), 64'h1);
    chk("addiw32_flags", 64'(ex_flags_32), 64'h40);
    if_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
